// File: rtl/fetch_ctrl_if.sv
// Fetch-block <-> fetch-control bundle: instruction/address/flag inward, redirect/hold controls outward.
// master = fetch block side, slave = fetch_ctrl_unit side.
interface fetch_ctrl_if;
  logic [23:0] ins;
  logic [7:0]  Current_Address;
  logic        zero_flag;
  logic [7:0]  jmp_loc;
  logic        pc_mux_sel;
  logic        Stall;
  logic        Stall_pm;
  logic        br_taken;

  modport master (
    output ins, Current_Address, zero_flag,
    input  jmp_loc, pc_mux_sel, Stall, Stall_pm, br_taken
  );

  modport slave (
    input  ins, Current_Address, zero_flag,
    output jmp_loc, pc_mux_sel, Stall, Stall_pm, br_taken
  );
endinterface

// File: rtl/fetch_ctrl_unit.sv
// Fetch control: resolves jumps, zero-flag branches and load-use hazards into
// registered PC redirect/hold controls for the fetch block.
module fetch_ctrl_unit #(
  parameter logic [4:0] OP_JMP   = 5'h10,
  parameter logic [4:0] OP_BZ    = 5'h11,
  parameter logic [4:0] OP_LD    = 5'h0C,
  parameter logic [4:0] OP_NOP   = 5'h00,
  parameter int         BR_LAT   = 2,
  parameter int         LD_STALL = 1
) (
  input logic          clk,
  input logic          reset,
  fetch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {RUN, LDSTALL, BRWAIT, REDIR} state_t;

  localparam logic [2:0] BR_CNT = 3'(BR_LAT - 1);
  localparam logic [2:0] LD_CNT = 3'(LD_STALL - 1);

  state_t      r_state, w_state;
  logic [7:0]  r_jmp_loc, w_jmp_loc;
  logic        r_pc_mux_sel, w_pc_mux_sel;
  logic        r_stall, w_stall;
  logic        r_stall_pm, w_stall_pm;
  logic        r_br_taken, w_br_taken;
  logic        r_ld_valid, w_ld_valid;
  logic [2:0]  r_ld_rd, w_ld_rd;
  logic [2:0]  r_cnt, w_cnt;

  logic [4:0]  w_opcode;
  logic [2:0]  w_rd, w_rs, w_rt;
  logic [7:0]  w_target;
  logic        w_load_use;
  logic        w_unused_bits;

  assign w_opcode = bus.ins[23:19];
  assign w_rd     = bus.ins[18:16];
  assign w_rs     = bus.ins[15:13];
  assign w_rt     = bus.ins[12:10];
  assign w_target = bus.ins[7:0];
  assign w_unused_bits = ^{bus.ins[9:8], bus.Current_Address};

  assign w_load_use = r_ld_valid && (w_opcode != OP_NOP) &&
                      ((w_rs == r_ld_rd) || (w_rt == r_ld_rd));

  always_comb begin
    w_state      = r_state;
    w_jmp_loc    = r_jmp_loc;
    w_pc_mux_sel = 1'b0;
    w_stall      = 1'b0;
    w_stall_pm   = 1'b0;
    w_br_taken   = 1'b0;
    w_ld_valid   = r_ld_valid;
    w_ld_rd      = r_ld_rd;
    w_cnt        = r_cnt;

    case (r_state)
      RUN: begin
        if (w_load_use) begin
          // Clearing ld_valid lets the held consumer pass cleanly once the bubble ends
          w_stall    = 1'b1;
          w_stall_pm = 1'b1;
          w_cnt      = LD_CNT;
          w_ld_valid = 1'b0;
          w_state    = LDSTALL;
        end else begin
          w_ld_valid = (w_opcode == OP_LD);
          w_ld_rd    = w_rd;
          if (w_opcode == OP_JMP) begin
            w_jmp_loc    = w_target;
            w_pc_mux_sel = 1'b1;
            w_stall_pm   = 1'b1;
            w_state      = REDIR;
          end else if (w_opcode == OP_BZ) begin
            w_jmp_loc  = w_target;
            w_stall    = 1'b1;
            w_stall_pm = 1'b1;
            w_cnt      = BR_CNT;
            w_state    = BRWAIT;
          end
        end
      end

      LDSTALL: begin
        if (r_cnt != 3'd0) begin
          w_stall    = 1'b1;
          w_stall_pm = 1'b1;
          w_cnt      = r_cnt - 3'd1;
        end else begin
          w_state = RUN;
        end
      end

      BRWAIT: begin
        // zero_flag is only trusted once the countdown has expired
        if (r_cnt != 3'd0) begin
          w_stall    = 1'b1;
          w_stall_pm = 1'b1;
          w_cnt      = r_cnt - 3'd1;
        end else if (bus.zero_flag) begin
          w_pc_mux_sel = 1'b1;
          w_stall_pm   = 1'b1;
          w_br_taken   = 1'b1;
          w_state      = REDIR;
        end else begin
          w_state = RUN;
        end
      end

      REDIR: begin
        w_ld_valid = 1'b0;
        w_state    = RUN;
      end

      default: w_state = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RUN;
      r_jmp_loc    <= 8'h00;
      r_pc_mux_sel <= 1'b0;
      r_stall      <= 1'b0;
      r_stall_pm   <= 1'b0;
      r_br_taken   <= 1'b0;
      r_ld_valid   <= 1'b0;
      r_ld_rd      <= 3'd0;
      r_cnt        <= 3'd0;
    end else begin
      r_state      <= w_state;
      r_jmp_loc    <= w_jmp_loc;
      r_pc_mux_sel <= w_pc_mux_sel;
      r_stall      <= w_stall;
      r_stall_pm   <= w_stall_pm;
      r_br_taken   <= w_br_taken;
      r_ld_valid   <= w_ld_valid;
      r_ld_rd      <= w_ld_rd;
      r_cnt        <= w_cnt;
    end
  end

  assign bus.jmp_loc    = r_jmp_loc;
  assign bus.pc_mux_sel = r_pc_mux_sel;
  assign bus.Stall      = r_stall;
  assign bus.Stall_pm   = r_stall_pm;
  assign bus.br_taken   = r_br_taken;

endmodule

// File: tb/tb_fetch_ctrl_unit.sv
// Scoreboard bench for fetch_ctrl_unit: each driven cycle queues the expected
// {jmp_loc, pc_mux_sel, Stall, Stall_pm, br_taken} and the post-edge output is checked.
module tb_fetch_ctrl_unit;

  localparam logic [4:0] OP_JMP = 5'h10;
  localparam logic [4:0] OP_BZ  = 5'h11;
  localparam logic [4:0] OP_LD  = 5'h0C;
  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_ADD = 5'h01;

  logic clk;
  logic reset;
  logic [7:0] curAddr;

  int totalChecks = 0;
  int badChecks   = 0;

  logic [11:0] expQ[$];
  string       tagQ[$];

  fetch_ctrl_if bus();

  fetch_ctrl_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] mkIns(input logic [4:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt,
                                        input logic [7:0] tgt);
    return {op, rd, rs, rt, 2'b00, tgt};
  endfunction

  function automatic logic [11:0] mkExp(input logic [7:0] jl, input logic pms,
                                        input logic st, input logic spm, input logic br);
    return {jl, pms, st, spm, br};
  endfunction

  task automatic checkOutput(input string tag, input logic [11:0] observed,
                             input logic [11:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic applyStimulus(input string tag, input logic rst, input logic [23:0] insV,
                               input logic zf, input logic [11:0] expV);
    logic [11:0] obs;
    logic [11:0] want;
    string       t;
    @(negedge clk);
    reset               = rst;
    bus.ins             = insV;
    bus.zero_flag       = zf;
    bus.Current_Address = curAddr;
    expQ.push_back(expV);
    tagQ.push_back(tag);
    @(posedge clk);
    #1;
    obs  = {bus.jmp_loc, bus.pc_mux_sel, bus.Stall, bus.Stall_pm, bus.br_taken};
    want = expQ.pop_front();
    t    = tagQ.pop_front();
    checkOutput(t, obs, want);
    checkOutput({t, "_excl"}, {11'd0, bus.Stall & bus.pc_mux_sel}, 12'd0);
  endtask

  initial begin
    reset               = 1'b1;
    curAddr             = 8'h10;
    bus.ins             = 24'd0;
    bus.zero_flag       = 1'b0;
    bus.Current_Address = 8'h10;

    applyStimulus("rst0",      1'b1, mkIns(OP_JMP, 3'd0, 3'd0, 3'd0, 8'h08), 1'b0, mkExp(8'h00, 0, 0, 0, 0));
    applyStimulus("rst1",      1'b1, mkIns(OP_JMP, 3'd0, 3'd0, 3'd0, 8'h08), 1'b0, mkExp(8'h00, 0, 0, 0, 0));
    applyStimulus("jmpStart",  1'b0, mkIns(OP_JMP, 3'd0, 3'd0, 3'd0, 8'h08), 1'b0, mkExp(8'h08, 1, 0, 1, 0));
    applyStimulus("jmpEnd",    1'b0, mkIns(OP_NOP, 3'd0, 3'd0, 3'd0, 8'h00), 1'b0, mkExp(8'h08, 0, 0, 0, 0));
    applyStimulus("idle",      1'b0, mkIns(OP_NOP, 3'd0, 3'd0, 3'd0, 8'h00), 1'b0, mkExp(8'h08, 0, 0, 0, 0));

    // A load fetched in the redirect slot is squashed and must not cause a hazard
    applyStimulus("jmp3C",     1'b0, mkIns(OP_JMP, 3'd0, 3'd0, 3'd0, 8'h3C), 1'b0, mkExp(8'h3C, 1, 0, 1, 0));
    applyStimulus("sqLd",      1'b0, mkIns(OP_LD,  3'd3, 3'd0, 3'd0, 8'h00), 1'b0, mkExp(8'h3C, 0, 0, 0, 0));
    applyStimulus("sqNoHaz",   1'b0, mkIns(OP_ADD, 3'd1, 3'd3, 3'd0, 8'h00), 1'b0, mkExp(8'h3C, 0, 0, 0, 0));

    applyStimulus("bzT_w1",    1'b0, mkIns(OP_BZ,  3'd0, 3'd0, 3'd0, 8'h20), 1'b0, mkExp(8'h20, 0, 1, 1, 0));
    applyStimulus("bzT_w2",    1'b0, mkIns(OP_BZ,  3'd0, 3'd0, 3'd0, 8'h20), 1'b0, mkExp(8'h20, 0, 1, 1, 0));
    applyStimulus("bzT_res",   1'b0, mkIns(OP_BZ,  3'd0, 3'd0, 3'd0, 8'h20), 1'b1, mkExp(8'h20, 1, 0, 1, 1));
    applyStimulus("bzT_end",   1'b0, mkIns(OP_NOP, 3'd0, 3'd0, 3'd0, 8'h00), 1'b0, mkExp(8'h20, 0, 0, 0, 0));

    applyStimulus("bzN_w1",    1'b0, mkIns(OP_BZ,  3'd0, 3'd0, 3'd0, 8'h21), 1'b1, mkExp(8'h21, 0, 1, 1, 0));
    applyStimulus("bzN_w2",    1'b0, mkIns(OP_BZ,  3'd0, 3'd0, 3'd0, 8'h21), 1'b1, mkExp(8'h21, 0, 1, 1, 0));
    applyStimulus("bzN_res",   1'b0, mkIns(OP_BZ,  3'd0, 3'd0, 3'd0, 8'h21), 1'b0, mkExp(8'h21, 0, 0, 0, 0));
    applyStimulus("bzN_after", 1'b0, mkIns(OP_NOP, 3'd0, 3'd0, 3'd0, 8'h00), 1'b0, mkExp(8'h21, 0, 0, 0, 0));

    applyStimulus("ldRs",      1'b0, mkIns(OP_LD,  3'd3, 3'd0, 3'd0, 8'h00), 1'b0, mkExp(8'h21, 0, 0, 0, 0));
    applyStimulus("useRs",     1'b0, mkIns(OP_ADD, 3'd1, 3'd3, 3'd0, 8'h00), 1'b0, mkExp(8'h21, 0, 1, 1, 0));
    applyStimulus("useRsEnd",  1'b0, mkIns(OP_ADD, 3'd1, 3'd3, 3'd0, 8'h00), 1'b0, mkExp(8'h21, 0, 0, 0, 0));
    applyStimulus("useRsRe",   1'b0, mkIns(OP_ADD, 3'd1, 3'd3, 3'd0, 8'h00), 1'b0, mkExp(8'h21, 0, 0, 0, 0));

    applyStimulus("ldMiss",    1'b0, mkIns(OP_LD,  3'd3, 3'd0, 3'd0, 8'h00), 1'b0, mkExp(8'h21, 0, 0, 0, 0));
    applyStimulus("noHaz",     1'b0, mkIns(OP_ADD, 3'd1, 3'd2, 3'd2, 8'h00), 1'b0, mkExp(8'h21, 0, 0, 0, 0));

    applyStimulus("ldRt",      1'b0, mkIns(OP_LD,  3'd5, 3'd0, 3'd0, 8'h00), 1'b0, mkExp(8'h21, 0, 0, 0, 0));
    applyStimulus("useRt",     1'b0, mkIns(OP_ADD, 3'd1, 3'd0, 3'd5, 8'h00), 1'b0, mkExp(8'h21, 0, 1, 1, 0));
    applyStimulus("useRtEnd",  1'b0, mkIns(OP_ADD, 3'd1, 3'd0, 3'd5, 8'h00), 1'b0, mkExp(8'h21, 0, 0, 0, 0));

    applyStimulus("ldR0",      1'b0, mkIns(OP_LD,  3'd0, 3'd0, 3'd0, 8'h00), 1'b0, mkExp(8'h21, 0, 0, 0, 0));
    applyStimulus("nopNoHaz",  1'b0, mkIns(OP_NOP, 3'd0, 3'd0, 3'd0, 8'h00), 1'b0, mkExp(8'h21, 0, 0, 0, 0));

    // Load-use outranks a jump; the jump is taken once the bubble clears
    applyStimulus("ldJ",       1'b0, mkIns(OP_LD,  3'd4, 3'd0, 3'd0, 8'h00), 1'b0, mkExp(8'h21, 0, 0, 0, 0));
    applyStimulus("jmpHaz",    1'b0, mkIns(OP_JMP, 3'd0, 3'd4, 3'd0, 8'h44), 1'b0, mkExp(8'h21, 0, 1, 1, 0));
    applyStimulus("jmpHazEnd", 1'b0, mkIns(OP_JMP, 3'd0, 3'd4, 3'd0, 8'h44), 1'b0, mkExp(8'h21, 0, 0, 0, 0));
    applyStimulus("jmpAfter",  1'b0, mkIns(OP_JMP, 3'd0, 3'd4, 3'd0, 8'h44), 1'b0, mkExp(8'h44, 1, 0, 1, 0));
    applyStimulus("jmpAftEnd", 1'b0, mkIns(OP_NOP, 3'd0, 3'd0, 3'd0, 8'h00), 1'b0, mkExp(8'h44, 0, 0, 0, 0));

    applyStimulus("bzRst_w1",  1'b0, mkIns(OP_BZ,  3'd0, 3'd0, 3'd0, 8'h30), 1'b1, mkExp(8'h30, 0, 1, 1, 0));
    applyStimulus("bzRst_rst", 1'b1, mkIns(OP_BZ,  3'd0, 3'd0, 3'd0, 8'h30), 1'b1, mkExp(8'h00, 0, 0, 0, 0));
    applyStimulus("bzRst_p1",  1'b0, mkIns(OP_NOP, 3'd0, 3'd0, 3'd0, 8'h00), 1'b1, mkExp(8'h00, 0, 0, 0, 0));
    applyStimulus("bzRst_p2",  1'b0, mkIns(OP_NOP, 3'd0, 3'd0, 3'd0, 8'h00), 1'b1, mkExp(8'h00, 0, 0, 0, 0));

    curAddr = 8'h50;
    applyStimulus("selfJmp",   1'b0, mkIns(OP_JMP, 3'd0, 3'd0, 3'd0, 8'h50), 1'b0, mkExp(8'h50, 1, 0, 1, 0));
    applyStimulus("selfEnd",   1'b0, mkIns(OP_NOP, 3'd0, 3'd0, 3'd0, 8'h00), 1'b0, mkExp(8'h50, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl_unit.md
Name: fetch_ctrl_unit

Overview:
Front-end control partner of the PC/instruction-memory fetch block. It consumes the fetched 24-bit instruction and its address, and drives that block's redirect and hold controls: jmp_loc, pc_mux_sel, Stall and Stall_pm. It handles unconditional jumps, zero-flag branches and load-use hazards with a small registered FSM, and sits between the fetch block and the decode stage.

Parameters:
OP_JMP, 5'h10, opcode of the unconditional jump (target = ins[7:0])
OP_BZ, 5'h11, opcode of branch-if-zero (target = ins[7:0], condition = zero_flag)
OP_LD, 5'h0C, opcode of the load (destination = ins[18:16])
OP_NOP, 5'h00, no-operation opcode; never causes a hazard
BR_LAT, 2, cycles from BZ detection until zero_flag is valid (1..7)
LD_STALL, 1, bubble cycles inserted on a load-use hazard (1..3)

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
ins  input  24  current fetched instruction from the fetch block
Current_Address  input  8  address of ins
zero_flag  input  1  ALU zero flag from EX; sampled only at branch resolution
jmp_loc  output  8  redirect target for the PC mux
pc_mux_sel  output  1  1 = PC loads jmp_loc next edge; 0 = PC increments
Stall  output  1  1 = hold PC
Stall_pm  output  1  1 = hold/bubble the instruction-memory output register
br_taken  output  1  one-cycle pulse when a BZ resolves taken (debug/perf)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Instruction fields: opcode = ins[23:19], rd = ins[18:16], rs = ins[15:13], rt = ins[12:10], target = ins[7:0].
- All outputs are registered. A decision made at posedge N is visible after posedge N.
- Reset (sampled high at posedge):
  - jmp_loc = 8'h00; pc_mux_sel, Stall, Stall_pm, br_taken = 0.
  - FSM goes to RUN; ld_valid = 0; counter = 0.
  - Reset mid-operation aborts any stall, wait or redirect in the same edge.
- FSM states: RUN, LDSTALL, BRWAIT, REDIR.
- RUN, evaluated at each posedge in priority order:
  1. Load-use: ld_valid and opcode != OP_NOP and (rs == ld_rd or rt == ld_rd).
     - Set Stall = 1, Stall_pm = 1, counter = LD_STALL-1, go to LDSTALL.
     - Clear ld_valid. The instruction is re-evaluated after the stall, with no hazard.
  2. OP_JMP:
     - jmp_loc = target, pc_mux_sel = 1, Stall_pm = 1 (squash the wrong-path fetch), go to REDIR.
  3. OP_BZ:
     - jmp_loc = target, Stall = 1, Stall_pm = 1, counter = BR_LAT-1, go to BRWAIT.
  4. Otherwise: all controls 0, stay in RUN.
  - In every RUN case except load-use: ld_valid = (opcode == OP_LD); ld_rd = rd.
- LDSTALL:
  - Hold Stall = Stall_pm = 1 while counter != 0, decrementing each cycle.
  - At counter == 0: clear both and return to RUN.
  - Total bubble = LD_STALL cycles.
- BRWAIT:
  - Stall = Stall_pm = 1, counter decrements; ins is ignored.
  - At counter == 0, sample zero_flag:
    - 1: pc_mux_sel = 1, Stall = 0, Stall_pm = 1, br_taken = 1 for one cycle, go to REDIR.
    - 0: Stall = Stall_pm = 0, go to RUN.
  - Total hold = BR_LAT cycles.
- REDIR:
  - Lasts exactly one cycle, then pc_mux_sel = 0, Stall_pm = 0, br_taken = 0, go to RUN.
  - ld_valid is cleared: the squashed instruction never creates a hazard.
- jmp_loc retains its last value outside redirects. Jump to self (target == Current_Address) is legal and loops.
- Current_Address is only compared, never modified; wrap-around of the 8-bit PC is the fetch block's concern.
- Stall and pc_mux_sel are never both 1.

Test Plan:
- Reset: hold reset 2 cycles with ins = {OP_JMP, …, 8'h08} -> all outputs 0 and jmp_loc = 8'h00 during and one cycle after reset; the first post-reset edge starts the jump.
- Jump: ins = {5'h10, 11'h0, 8'h08} in RUN -> next cycle jmp_loc = 8'h08, pc_mux_sel = 1, Stall_pm = 1 for exactly 1 cycle, then all 0.
- Branch taken: ins = {5'h11, …, 8'h20}, BR_LAT = 2, zero_flag = 1 at resolution -> Stall = 1 for 2 cycles, then pc_mux_sel = 1, br_taken = 1, jmp_loc = 8'h20 for 1 cycle.
- Branch not taken: same stimulus with zero_flag = 0 -> Stall = 1 for 2 cycles, then all controls 0, pc_mux_sel never 1, br_taken never 1.
- Load-use: LD rd = 3, then ADD rs = 3 -> Stall = Stall_pm = 1 for LD_STALL (1) cycle, then 0. Repeat with rs = rt = 2 -> no stall.
- Reset mid-BRWAIT: assert reset in the 1st wait cycle -> next edge all outputs 0, FSM in RUN, no redirect follows.
